// File: rtl/stage_sequencer_pkg.sv
// Shared definitions for the stage sequencer.
// Holds the state encoding (the state code is also the visible ClockCount),
// the Inst_Class codes, the MuxY select codes and the default MFC timeout.
package stage_sequencer_pkg;

  // The state value is exported as ClockCount, so the encoding is fixed.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEMORY    = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_FAULT     = 3'd6
  } state_t;

  // Inst_Class codes; 6 and 7 are illegal.
  localparam logic [2:0] CLASS_ALU    = 3'd0;
  localparam logic [2:0] CLASS_LOAD   = 3'd1;
  localparam logic [2:0] CLASS_STORE  = 3'd2;
  localparam logic [2:0] CLASS_BRANCH = 3'd3;
  localparam logic [2:0] CLASS_CALL   = 3'd4;
  localparam logic [2:0] CLASS_NOP    = 3'd5;

  // MuxY select codes.
  localparam logic [1:0] Y_RZ      = 2'd0;
  localparam logic [1:0] Y_MEM_OUT = 2'd1;
  localparam logic [1:0] Y_RET_ADR = 2'd2;

  localparam int DEFAULT_MFC_TIMEOUT = 16;

  function automatic logic is_legal_class(input logic [2:0] cls);
    return cls <= CLASS_NOP;
  endfunction

  function automatic logic is_mem_class(input logic [2:0] cls);
    return (cls == CLASS_LOAD) || (cls == CLASS_STORE);
  endfunction

endpackage

// File: rtl/stage_sequencer_mfc_watchdog.sv
// mfc_watchdog: counts memory-step cycles spent waiting for MFC.
// Used only when MFC_TIMEOUT_EN is defined.
// Ports:
//   clk, rst_n     clock and asynchronous active-low reset
//   clear          return the count to zero (not waiting in the memory step)
//   count          one more cycle of waiting for MFC
//   expire         this waiting cycle is the last one allowed
module mfc_watchdog
  import stage_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_MFC_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (count) begin
      cnt <= cnt + CW'(1);
    end
  end

  // The cycle that would make the count reach TIMEOUT_CYCLES is the
  // expiring one, so the sequencer leaves the memory step after exactly
  // TIMEOUT_CYCLES waiting cycles.
  assign expire = count && (cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/stage_sequencer.sv
// stage_sequencer: five-step instruction control sequencer for a simple
// processor datapath (fetch, decode, execute, memory, writeback) with a
// sticky fault state.
// Build option: define MFC_TIMEOUT_EN to fault after MFC_TIMEOUT_CYCLES
// cycles of waiting for MFC; without it the memory step waits indefinitely.
// Ports:
//   Clock, ProcessorReset_L       clock, asynchronous active-low reset
//   ProcessorEnable               run request (level)
//   Inst_Class[2:0]               decoded instruction class, captured in step 2
//   Branch_Taken                  condition result, used in step 3
//   MFC                           memory-function-complete handshake
//   *_Enable, ROM_Read, RF_WRITE  datapath strobes
//   *_Select, MEM_*               mux selects and RAM control
//   Y_Select[1:0]                 MuxY select
//   ClockCount[2:0]               step code (0 idle, 1-5 steps, 6 fault)
//   OperationFinished             pulse in the last step of each instruction
//   Fault                         sticky fault indication
module stage_sequencer
  import stage_sequencer_pkg::*;
#(
  parameter int MFC_TIMEOUT_CYCLES = DEFAULT_MFC_TIMEOUT
) (
  input  logic       Clock,
  input  logic       ProcessorReset_L,
  input  logic       ProcessorEnable,
  input  logic [2:0] Inst_Class,
  input  logic       Branch_Taken,
  input  logic       MFC,
  output logic       ROM_Read,
  output logic       IR_Enable,
  output logic       PC_Enable,
  output logic       RA_Enable,
  output logic       RB_Enable,
  output logic       RZ_Enable,
  output logic       RM_Enable,
  output logic       CCR_Enable,
  output logic       RY_Enable,
  output logic       RF_WRITE,
  output logic       PC_Select,
  output logic       INC_Select,
  output logic       B_Select,
  output logic       C_Select,
  output logic       MA_Select,
  output logic       MEM_Read_H_Write_L,
  output logic       MEM_Request,
  output logic [1:0] Y_Select,
  output logic [2:0] ClockCount,
  output logic       OperationFinished,
  output logic       Fault
);

  if (MFC_TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("MFC_TIMEOUT_CYCLES must be at least 1");
  end

  state_t     state;
  state_t     state_nxt;
  logic [2:0] class_q;
  logic       mem_wait;
  logic       timeout;

  // NOTE: state is a flop, so it is written with non-blocking assignments;
  // the async reset also drops every Moore-decoded output immediately.
  always_ff @(posedge Clock or negedge ProcessorReset_L) begin
    if (!ProcessorReset_L) begin
      state   <= ST_IDLE;
      class_q <= CLASS_ALU;
    end else begin
      state <= state_nxt;
      if (state == ST_DECODE) begin
        class_q <= Inst_Class;
      end
    end
  end

  // A load/store still waiting for the RAM handshake.
  assign mem_wait = (state == ST_MEMORY) && is_mem_class(class_q) && !MFC;

`ifdef MFC_TIMEOUT_EN
  mfc_watchdog #(
    .TIMEOUT_CYCLES(MFC_TIMEOUT_CYCLES)
  ) u_mfc_watchdog (
    .clk   (Clock),
    .rst_n (ProcessorReset_L),
    .clear (state != ST_MEMORY),
    .count (mem_wait),
    .expire(timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (ProcessorEnable) state_nxt = ST_FETCH;
      ST_FETCH:     state_nxt = ST_DECODE;
      ST_DECODE:    state_nxt = is_legal_class(Inst_Class) ? ST_EXECUTE : ST_FAULT;
      ST_EXECUTE:   state_nxt = ST_MEMORY;
      ST_MEMORY: begin
        if (!mem_wait)    state_nxt = ST_WRITEBACK;
        else if (timeout) state_nxt = ST_FAULT;
      end
      ST_WRITEBACK: state_nxt = ProcessorEnable ? ST_FETCH : ST_IDLE;
      ST_FAULT:     state_nxt = ST_FAULT;
      default:      state_nxt = ST_FAULT;
    endcase
  end

  // NOTE: every output gets a default before the case so no path through
  // this block leaves a latch behind.
  always_comb begin
    ROM_Read           = 1'b0;
    IR_Enable          = 1'b0;
    PC_Enable          = 1'b0;
    RA_Enable          = 1'b0;
    RB_Enable          = 1'b0;
    RZ_Enable          = 1'b0;
    RM_Enable          = 1'b0;
    CCR_Enable         = 1'b0;
    RY_Enable          = 1'b0;
    RF_WRITE           = 1'b0;
    PC_Select          = 1'b0;
    INC_Select         = 1'b0;
    B_Select           = 1'b0;
    C_Select           = 1'b0;
    MA_Select          = 1'b0;
    MEM_Read_H_Write_L = 1'b0;
    MEM_Request        = 1'b0;
    Y_Select           = Y_RZ;
    OperationFinished  = 1'b0;
    ClockCount         = state;
    Fault              = (state == ST_FAULT);

    case (state)
      ST_FETCH: begin
        ROM_Read   = 1'b1;
        IR_Enable  = 1'b1;
        PC_Enable  = 1'b1;
        INC_Select = 1'b1;
      end
      ST_DECODE: begin
        RA_Enable = 1'b1;
        RB_Enable = 1'b1;
      end
      ST_EXECUTE: begin
        RZ_Enable  = 1'b1;
        CCR_Enable = 1'b1;
        // A NOP has nothing to store, so RM stays closed.
        RM_Enable  = (class_q != CLASS_NOP);
        B_Select   = is_mem_class(class_q);
        if ((class_q == CLASS_CALL) ||
            ((class_q == CLASS_BRANCH) && Branch_Taken)) begin
          PC_Enable = 1'b1;
          PC_Select = 1'b1;
        end
      end
      ST_MEMORY: begin
        if (is_mem_class(class_q)) begin
          MEM_Request        = 1'b1;
          MEM_Read_H_Write_L = (class_q == CLASS_LOAD);
          RY_Enable          = MFC;
        end else begin
          RY_Enable = 1'b1;
        end
        if (class_q == CLASS_LOAD)      Y_Select = Y_MEM_OUT;
        else if (class_q == CLASS_CALL) Y_Select = Y_RET_ADR;
      end
      ST_WRITEBACK: begin
        RF_WRITE = (class_q == CLASS_ALU) || (class_q == CLASS_LOAD) ||
                   (class_q == CLASS_CALL);
        // CALL writes the return address into the link register.
        C_Select          = (class_q == CLASS_CALL);
        OperationFinished = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed self-checking bench for stage_sequencer. All outputs are packed
// into one 24-bit word and compared against hand-built expected words.
module tb_stage_sequencer;

  logic       Clock;
  logic       ProcessorReset_L;
  logic       ProcessorEnable;
  logic [2:0] Inst_Class;
  logic       Branch_Taken;
  logic       MFC;
  logic       ROM_Read, IR_Enable, PC_Enable, RA_Enable, RB_Enable, RZ_Enable;
  logic       RM_Enable, CCR_Enable, RY_Enable, RF_WRITE;
  logic       PC_Select, INC_Select, B_Select, C_Select, MA_Select;
  logic       MEM_Read_H_Write_L, MEM_Request;
  logic [1:0] Y_Select;
  logic [2:0] ClockCount;
  logic       OperationFinished, Fault;

  int checks = 0;
  int errors = 0;

  stage_sequencer dut (
    .Clock             (Clock),
    .ProcessorReset_L  (ProcessorReset_L),
    .ProcessorEnable   (ProcessorEnable),
    .Inst_Class        (Inst_Class),
    .Branch_Taken      (Branch_Taken),
    .MFC               (MFC),
    .ROM_Read          (ROM_Read),
    .IR_Enable         (IR_Enable),
    .PC_Enable         (PC_Enable),
    .RA_Enable         (RA_Enable),
    .RB_Enable         (RB_Enable),
    .RZ_Enable         (RZ_Enable),
    .RM_Enable         (RM_Enable),
    .CCR_Enable        (CCR_Enable),
    .RY_Enable         (RY_Enable),
    .RF_WRITE          (RF_WRITE),
    .PC_Select         (PC_Select),
    .INC_Select        (INC_Select),
    .B_Select          (B_Select),
    .C_Select          (C_Select),
    .MA_Select         (MA_Select),
    .MEM_Read_H_Write_L(MEM_Read_H_Write_L),
    .MEM_Request       (MEM_Request),
    .Y_Select          (Y_Select),
    .ClockCount        (ClockCount),
    .OperationFinished (OperationFinished),
    .Fault             (Fault)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic [23:0] vec;
  assign vec = {ROM_Read, IR_Enable, PC_Enable, RA_Enable, RB_Enable, RZ_Enable,
                RM_Enable, CCR_Enable, RY_Enable, RF_WRITE, PC_Select, INC_Select,
                B_Select, C_Select, MA_Select, MEM_Read_H_Write_L, MEM_Request,
                Y_Select, OperationFinished, Fault, ClockCount};

  // Bit positions within vec.
  localparam logic [23:0] ROM = 24'(1) << 23, IRE = 24'(1) << 22, PCE = 24'(1) << 21;
  localparam logic [23:0] RAE = 24'(1) << 20, RBE = 24'(1) << 19, RZE = 24'(1) << 18;
  localparam logic [23:0] RME = 24'(1) << 17, CCE = 24'(1) << 16, RYE = 24'(1) << 15;
  localparam logic [23:0] RFW = 24'(1) << 14, PCS = 24'(1) << 13, INC = 24'(1) << 12;
  localparam logic [23:0] BSL = 24'(1) << 11, CSL = 24'(1) << 10;
  localparam logic [23:0] MRW = 24'(1) << 8,  MRQ = 24'(1) << 7;
  localparam logic [23:0] Y1  = 24'(1) << 5,  Y2  = 24'(1) << 6;
  localparam logic [23:0] OPF = 24'(1) << 4,  FLT = 24'(1) << 3;

  // Hand-derived expected output words per step.
  localparam logic [23:0] E_IDLE      = 24'd0;
  localparam logic [23:0] E_S1        = ROM | IRE | PCE | INC | 24'd1;
  localparam logic [23:0] E_S2        = RAE | RBE | 24'd2;
  localparam logic [23:0] E_S3        = RZE | RME | CCE | 24'd3;
  localparam logic [23:0] E_S3_MEM    = RZE | RME | CCE | BSL | 24'd3;
  localparam logic [23:0] E_S3_JMP    = RZE | RME | CCE | PCE | PCS | 24'd3;
  localparam logic [23:0] E_S3_NOP    = RZE | CCE | 24'd3;
  localparam logic [23:0] E_S4        = RYE | 24'd4;
  localparam logic [23:0] E_S4_CALL   = RYE | Y2 | 24'd4;
  localparam logic [23:0] E_S4_LD_W   = MRQ | MRW | Y1 | 24'd4;
  localparam logic [23:0] E_S4_LD_D   = MRQ | MRW | Y1 | RYE | 24'd4;
  localparam logic [23:0] E_S4_ST_W   = MRQ | 24'd4;
  localparam logic [23:0] E_S4_ST_D   = MRQ | RYE | 24'd4;
  localparam logic [23:0] E_S5_WB     = RFW | OPF | 24'd5;
  localparam logic [23:0] E_S5_CALL   = RFW | CSL | OPF | 24'd5;
  localparam logic [23:0] E_S5_NW     = OPF | 24'd5;
  localparam logic [23:0] E_FAULT     = FLT | 24'd6;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock, then compare the outputs well after the edge.
  task automatic tick(input string tag, input logic [23:0] exp);
    @(posedge Clock);
    #1;
    check(tag, {8'h0, vec}, {8'h0, exp});
  endtask

  initial begin
    ProcessorReset_L = 1'b0;
    ProcessorEnable  = 1'b0;
    Inst_Class       = 3'd0;
    Branch_Taken     = 1'b0;
    MFC              = 1'b0;
    #1;
    check("reset_outputs", {8'h0, vec}, {8'h0, E_IDLE});

    repeat (2) @(posedge Clock);
    #1;
    ProcessorReset_L = 1'b1;
    ProcessorEnable  = 1'b1;
    Inst_Class       = 3'd0;
    #1;
    check("idle_at_release", {8'h0, vec}, {8'h0, E_IDLE});

    // ALU: steps 1..5 then back to 1.
    tick("alu_s1", E_S1);
    tick("alu_s2", E_S2);
    tick("alu_s3", E_S3);
    tick("alu_s4", E_S4);
    tick("alu_s5", E_S5_WB);
    tick("alu_next_s1", E_S1);

    // LOAD with MFC after three wait cycles.
    Inst_Class = 3'd1;
    tick("ld_s2", E_S2);
    tick("ld_s3", E_S3_MEM);
    tick("ld_s4_wait1", E_S4_LD_W);
    tick("ld_s4_wait2", E_S4_LD_W);
    tick("ld_s4_wait3", E_S4_LD_W);
    tick("ld_s4_cyc4", E_S4_LD_W);
    MFC = 1'b1;
    #1;
    check("ld_s4_mfc", {8'h0, vec}, {8'h0, E_S4_LD_D});
    tick("ld_s5", E_S5_WB);
    MFC = 1'b0;
    tick("ld_next_s1", E_S1);

    // BRANCH taken.
    Inst_Class   = 3'd3;
    Branch_Taken = 1'b1;
    tick("brt_s2", E_S2);
    tick("brt_s3", E_S3_JMP);
    tick("brt_s4", E_S4);
    tick("brt_s5", E_S5_NW);
    tick("brt_next_s1", E_S1);

    // BRANCH not taken.
    Branch_Taken = 1'b0;
    tick("brn_s2", E_S2);
    tick("brn_s3", E_S3);
    tick("brn_s4", E_S4);
    tick("brn_s5", E_S5_NW);
    tick("brn_next_s1", E_S1);

    // CALL.
    Inst_Class = 3'd4;
    tick("call_s2", E_S2);
    tick("call_s3", E_S3_JMP);
    tick("call_s4", E_S4_CALL);
    tick("call_s5", E_S5_CALL);
    tick("call_next_s1", E_S1);

    // NOP.
    Inst_Class = 3'd5;
    tick("nop_s2", E_S2);
    tick("nop_s3", E_S3_NOP);
    tick("nop_s4", E_S4);
    tick("nop_s5", E_S5_NW);
    tick("nop_next_s1", E_S1);

    // STORE with MFC already high: ignored early, zero wait in step 4.
    Inst_Class = 3'd2;
    MFC        = 1'b1;
    tick("st_s2_mfc_ignored", E_S2);
    tick("st_s3", E_S3_MEM);
    tick("st_s4_zero_wait", E_S4_ST_D);
    tick("st_s5", E_S5_NW);
    MFC = 1'b0;
    tick("st_next_s1", E_S1);

    // Enable dropped in step 2: instruction completes, then idle.
    Inst_Class = 3'd0;
    tick("drop_s2", E_S2);
    ProcessorEnable = 1'b0;
    tick("drop_s3", E_S3);
    tick("drop_s4", E_S4);
    tick("drop_s5", E_S5_WB);
    tick("drop_idle", E_IDLE);
    tick("drop_idle_hold", E_IDLE);

    // Reset pulsed in the middle of a load's step 4.
    ProcessorEnable = 1'b1;
    Inst_Class      = 3'd1;
    tick("rst4_s1", E_S1);
    tick("rst4_s2", E_S2);
    tick("rst4_s3", E_S3_MEM);
    tick("rst4_s4", E_S4_LD_W);
    #2;
    ProcessorReset_L = 1'b0;
    #1;
    check("rst4_async_clear", {8'h0, vec}, {8'h0, E_IDLE});
    tick("rst4_held", E_IDLE);
    ProcessorReset_L = 1'b1;
    tick("rst4_first_s1", E_S1);

    // STORE with MFC held low: timeout fault or indefinite wait.
    Inst_Class = 3'd2;
    tick("to_s2", E_S2);
    tick("to_s3", E_S3_MEM);
    tick("to_s4_c1", E_S4_ST_W);
    for (int i = 2; i <= 16; i++) begin
      tick($sformatf("to_s4_c%0d", i), E_S4_ST_W);
    end
`ifdef MFC_TIMEOUT_EN
    tick("to_fault", E_FAULT);
    tick("to_fault_hold", E_FAULT);
`else
    tick("to_still_waiting", E_S4_ST_W);
    tick("to_still_waiting2", E_S4_ST_W);
`endif
    ProcessorReset_L = 1'b0;
    #1;
    check("to_reset", {8'h0, vec}, {8'h0, E_IDLE});
    @(posedge Clock);
    #1;
    ProcessorReset_L = 1'b1;
    tick("ill_s1", E_S1);

    // Illegal class: fault after step 2, sticky until reset.
    Inst_Class = 3'd7;
    tick("ill_s2", E_S2);
    tick("ill_fault", E_FAULT);
    ProcessorEnable = 1'b0;
    tick("ill_fault_hold1", E_FAULT);
    ProcessorEnable = 1'b1;
    Inst_Class      = 3'd0;
    tick("ill_fault_hold2", E_FAULT);
    ProcessorReset_L = 1'b0;
    #1;
    check("ill_reset_clears", {8'h0, vec}, {8'h0, E_IDLE});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
